// File: rtl/serial_add_pkg.sv
// ============================================================================
//  Module : serial_add_pkg
//  Brief  : Shared state encoding and width helper for the serial add sequencer
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package serial_add_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_shift_reg.sv
// ============================================================================
//  Module : serial_shift_reg
//  Brief  : Parallel-load, right-shifting register with serial input at the MSB
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_shift_reg #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_shift,
  input  logic             i_ser_in,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Load wins over shift so a fresh operand is never corrupted by a stale shift
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_load_val;
    end else if (i_shift) begin
      r_q <= {i_ser_in, r_q[WIDTH-1:1]};
    end
  end

  assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/serial_add_sequencer.sv
// ============================================================================
//  Module : serial_add_sequencer
//  Brief  : Drives one external full-adder cell LSB-first over WIDTH-bit operands
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_add_sequencer
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SUB,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             CARRY,
  output logic             OVF,
  output logic             FA_I0,
  output logic             FA_I1,
  output logic             FA_CIN,
  input  logic             FA_O,
  input  logic             FA_COUT
);

  localparam int            CW         = cnt_width(WIDTH);
  localparam logic [CW-1:0] C_CNT_PEN  = CW'(WIDTH - 2);
  localparam logic [CW-1:0] C_CNT_LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_count;
  logic             r_carry;
  logic             r_ovf_c;
  logic             r_carry_out;
  logic             r_ovf;

  logic             w_accept;
  logic             w_run;
  logic             w_last;
  logic [WIDTH-1:0] w_b_load;
  logic [WIDTH-1:0] w_a_q;
  logic [WIDTH-1:0] w_b_q;
  logic [WIDTH-1:0] w_sum_q;
  logic             w_unused;

  assign w_accept = (r_state == S_IDLE) && IN_VALID;
  assign w_run    = (r_state == S_RUN);
  assign w_last   = w_run && (r_count == C_CNT_LAST);
  assign w_b_load = SUB ? ~B : B;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (IN_VALID)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  if (OUT_READY) w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  // The carry into the MSB is captured one bit early so overflow is carry_in ^ carry_out of the sign bit
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_count     <= '0;
      r_carry     <= 1'b0;
      r_ovf_c     <= 1'b0;
      r_carry_out <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_accept) begin
      r_count <= '0;
      r_carry <= SUB;
    end else if (w_run) begin
      r_count <= r_count + CW'(1);
      r_carry <= FA_COUT;
      if (r_count == C_CNT_PEN) begin
        r_ovf_c <= FA_COUT;
      end
      if (w_last) begin
        r_carry_out <= FA_COUT;
        r_ovf       <= r_ovf_c ^ FA_COUT;
      end
    end
  end

  serial_shift_reg #(.WIDTH(WIDTH)) u_a_sh (
    .i_clk      (CLK),
    .i_rst_n    (RESETN),
    .i_load     (w_accept),
    .i_load_val (A),
    .i_shift    (w_run),
    .i_ser_in   (1'b0),
    .o_q        (w_a_q)
  );

  serial_shift_reg #(.WIDTH(WIDTH)) u_b_sh (
    .i_clk      (CLK),
    .i_rst_n    (RESETN),
    .i_load     (w_accept),
    .i_load_val (w_b_load),
    .i_shift    (w_run),
    .i_ser_in   (1'b0),
    .o_q        (w_b_q)
  );

  serial_shift_reg #(.WIDTH(WIDTH)) u_sum_sh (
    .i_clk      (CLK),
    .i_rst_n    (RESETN),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_shift    (w_run),
    .i_ser_in   (FA_O),
    .o_q        (w_sum_q)
  );

  assign w_unused = ^{w_a_q[WIDTH-1:1], w_b_q[WIDTH-1:1]};

  assign IN_READY  = (r_state == S_IDLE);
  assign OUT_VALID = (r_state == S_DONE);
  assign SUM       = w_sum_q;
  assign CARRY     = r_carry_out;
  assign OVF       = r_ovf;

  // Gate the cell inputs outside RUN so the shared adder stays quiet
  assign FA_I0  = w_run & w_a_q[0];
  assign FA_I1  = w_run & w_b_q[0];
  assign FA_CIN = w_run & r_carry;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_sequencer.sv
// ============================================================================
//  Module : tb_serial_add_sequencer
//  Brief  : Self-checking bench with a behavioural full adder and arithmetic model
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_add_sequencer;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RESETN = 1'b0;
  logic         IN_VALID = 1'b0;
  logic         IN_READY;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         SUB = 1'b0;
  logic         OUT_VALID;
  logic         OUT_READY = 1'b0;
  logic [W-1:0] SUM;
  logic         CARRY;
  logic         OVF;
  logic         FA_I0, FA_I1, FA_CIN, FA_O, FA_COUT;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  assign FA_O    = FA_I0 ^ FA_I1 ^ FA_CIN;
  assign FA_COUT = (FA_I0 & FA_I1) | (FA_I0 & FA_CIN) | (FA_I1 & FA_CIN);

  serial_add_sequencer #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .RESETN    (RESETN),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .A         (A),
    .B         (B),
    .SUB       (SUB),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .SUM       (SUM),
    .CARRY     (CARRY),
    .OVF       (OVF),
    .FA_I0     (FA_I0),
    .FA_I1     (FA_I1),
    .FA_CIN    (FA_CIN),
    .FA_O      (FA_O),
    .FA_COUT   (FA_COUT)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: integer arithmetic on the operands, no bit-level modelling
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       output logic [W-1:0] s, output logic c, output logic o);
    int ua, ub, sa, sb, ur, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    ur = sub ? (ua - ub) : (ua + ub);
    sr = sub ? (sa - sb) : (sa + sb);
    s  = W'(ur);
    c  = sub ? (ua >= ub) : (ur > 255);
    o  = (sr > 127) || (sr < -128);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Counts edges after accept until OUT_VALID, bounded
  task automatic wait_done(output int lat);
    lat = 0;
    while (!OUT_VALID && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!IN_READY && k < 40) begin
      tick();
      k++;
    end
    check("idle_timeout", 32'(IN_READY), 32'd1);
  endtask

  task automatic handshake();
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    check("post_hs_valid", 32'(OUT_VALID), 32'd0);
    check("post_hs_ready", 32'(IN_READY), 32'd1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input int bp, input string tag);
    logic [W-1:0] es;
    logic         ec, eo;
    int           lat;
    model(a, b, sub, es, ec, eo);
    wait_idle();
    A = a; B = b; SUB = sub; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    A = W'($urandom); B = W'($urandom); SUB = 1'($urandom);
    check({tag, "_busy"}, 32'(IN_READY), 32'd0);
    wait_done(lat);
    check({tag, "_lat"}, 32'(lat), 32'(W));
    check({tag, "_sum"}, 32'(SUM), 32'(es));
    check({tag, "_carry"}, 32'(CARRY), 32'(ec));
    check({tag, "_ovf"}, 32'(OVF), 32'(eo));
    check({tag, "_fa_quiet"}, 32'({FA_I0, FA_I1, FA_CIN}), 32'd0);
    for (int i = 0; i < bp; i++) begin
      tick();
      check({tag, "_hold"}, 32'({OUT_VALID, CARRY, OVF, SUM}), 32'({1'b1, ec, eo, es}));
    end
    handshake();
  endtask

  initial begin
    logic [W-1:0] es;
    logic         ec, eo;
    int           lat;

    #1;
    check("rst_async", 32'({OUT_VALID, IN_READY, SUM, CARRY, OVF}), 32'({1'b0, 1'b1, 8'h00, 1'b0, 1'b0}));
    IN_VALID = 1'b1; A = 8'hAA; B = 8'h55;
    repeat (3) tick();
    check("rst_no_capture", 32'({OUT_VALID, IN_READY, FA_I0, FA_I1, FA_CIN}), 32'b01000);
    IN_VALID = 1'b0;
    RESETN = 1'b1;
    tick();

    run_op(8'h3C, 8'h05, 1'b0, 0, "add_basic");
    run_op(8'hFF, 8'h01, 1'b0, 1, "add_wrap");
    run_op(8'h7F, 8'h01, 1'b0, 0, "add_ovf");
    run_op(8'h80, 8'h01, 1'b1, 2, "sub_ovf");
    run_op(8'h05, 8'h07, 1'b1, 0, "sub_borrow");
    run_op(8'h07, 8'h05, 1'b1, 0, "sub_noborrow");

    // Back-pressure with a pending request held on the input
    wait_idle();
    A = 8'h12; B = 8'h34; SUB = 1'b0; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    wait_done(lat);
    check("bp_lat", 32'(lat), 32'd8);
    A = 8'h55; B = 8'h22; SUB = 1'b1; IN_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold", 32'({IN_READY, OUT_VALID, CARRY, OVF, SUM}), 32'({1'b0, 1'b1, 1'b0, 1'b0, 8'h46}));
    end
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    check("bp_hs_idle", 32'({IN_READY, OUT_VALID}), 32'b10);
    tick();
    IN_VALID = 1'b0;
    check("bp_second_accept", 32'(IN_READY), 32'd0);
    wait_done(lat);
    model(8'h55, 8'h22, 1'b1, es, ec, eo);
    check("bp2_lat", 32'(lat), 32'd8);
    check("bp2_result", 32'({CARRY, OVF, SUM}), 32'({ec, eo, es}));
    handshake();

    // Abort mid-RUN with reset
    A = 8'h9C; B = 8'h3A; SUB = 1'b0; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    repeat (3) tick();
    check("abort_running", 32'(IN_READY), 32'd0);
    #2 RESETN = 1'b0;
    #1;
    check("abort_rst_vals", 32'({OUT_VALID, IN_READY, SUM, CARRY, OVF, FA_I0, FA_I1, FA_CIN}),
          32'({1'b0, 1'b1, 8'h00, 5'b00000}));
    tick();
    RESETN = 1'b1;
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (OUT_VALID) lat++;
    end
    check("abort_no_valid", 32'(lat), 32'd0);
    run_op(8'h10, 8'h20, 1'b0, 0, "post_abort");

    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
